// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite render path.
package sprite_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StDone
  } anim_state_e;

  localparam int unsigned TRANSP_IDX_DEF = 0;
  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;

  // ROM word offset of the first pixel of a frame; frames are stored back-to-back.
  function automatic int unsigned frame_base(input int unsigned frame,
                                             input int unsigned spr_w,
                                             input int unsigned spr_h);
    return frame * spr_w * spr_h;
  endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation frame sequencer: steps cur_frame on frame ticks with per-frame hold,
// loop or one-shot termination. Loads requested by a start are applied at the next tick.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES = 8,
  parameter int unsigned HOLD_W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_frame_tick,
  input  logic                      i_start,
  input  logic [$clog2(FRAMES)-1:0] i_first,
  input  logic [$clog2(FRAMES)-1:0] i_last,
  input  logic [HOLD_W-1:0]         i_hold,
  input  logic                      i_loop,
  output logic [$clog2(FRAMES)-1:0] o_cur_frame,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned FW = $clog2(FRAMES);

  anim_state_e       r_state, w_state_nxt;
  logic [FW-1:0]     r_cur, w_cur_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_done, w_done_nxt;
  logic [FW-1:0]     w_first;

  // An inverted range collapses to a single frame at anim_last.
  assign w_first = (i_first > i_last) ? i_last : i_first;

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_hold_nxt  = r_hold;
    w_pend_nxt  = r_pend;
    w_done_nxt  = 1'b0;
    if (i_start) begin
      w_state_nxt = StPlay;
      w_pend_nxt  = 1'b1;
    end
    if (i_frame_tick && (w_state_nxt == StPlay)) begin
      if (w_pend_nxt) begin
        w_cur_nxt  = w_first;
        w_hold_nxt = i_hold;
        w_pend_nxt = 1'b0;
      end else if (r_hold != '0) begin
        w_hold_nxt = r_hold - 1'b1;
      end else if (r_cur < i_last) begin
        w_cur_nxt  = r_cur + 1'b1;
        w_hold_nxt = i_hold;
      end else if (i_loop) begin
        w_cur_nxt  = w_first;
        w_hold_nxt = i_hold;
      end else begin
        w_state_nxt = StDone;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_cur   <= '0;
      r_hold  <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_hold  <= w_hold_nxt;
      r_pend  <= w_pend_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_cur_frame = r_cur;
  assign o_busy      = (r_state == StPlay);
  assign o_done      = r_done;

endmodule

// File: rtl/sprite_anim_renderer.sv
// Sprite pixel engine: box hit test, ROM address generation and registered palette output.
// Define SPRITE_FLIP_EN to honour i_flip_h (horizontal mirroring); otherwise it is ignored.
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 96,
  parameter int unsigned FRAMES     = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned HOLD_W     = 4,
  parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEF,
  parameter int unsigned ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic                      i_vga_clk,
  input  logic                      i_reset_n,
  input  logic [POS_W-1:0]          i_draw_x,
  input  logic [POS_W-1:0]          i_draw_y,
  input  logic                      i_blank,
  input  logic                      i_frame_tick,
  input  logic [POS_W-1:0]          i_pos_x,
  input  logic [POS_W-1:0]          i_pos_y,
  input  logic                      i_flip_h,
  input  logic                      i_anim_start,
  input  logic [$clog2(FRAMES)-1:0] i_anim_first,
  input  logic [$clog2(FRAMES)-1:0] i_anim_last,
  input  logic [HOLD_W-1:0]         i_anim_hold,
  input  logic                      i_anim_loop,
  output logic [ADDR_W-1:0]         o_rom_addr,
  input  logic [IDX_W-1:0]          i_rom_q,
  output logic [IDX_W-1:0]          o_pix_idx,
  output logic                      o_pix_opaque,
  output logic                      o_anim_busy,
  output logic                      o_anim_done
);

  logic [POS_W-1:0]          r_pos_x_sh, r_pos_y_sh;
  logic [POS_W:0]            w_dx, w_dy, w_col;
  logic                      w_hit, r_hit_d;
  logic [ADDR_W-1:0]         w_rom_addr, r_rom_addr;
  logic [IDX_W-1:0]          r_pix_idx;
  logic                      r_pix_opaque;
  logic [$clog2(FRAMES)-1:0] w_cur_frame;

  sprite_anim_seq #(
    .FRAMES (FRAMES),
    .HOLD_W (HOLD_W)
  ) u_seq (
    .i_clk        (i_vga_clk),
    .i_reset_n    (i_reset_n),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_anim_start),
    .i_first      (i_anim_first),
    .i_last       (i_anim_last),
    .i_hold       (i_anim_hold),
    .i_loop       (i_anim_loop),
    .o_cur_frame  (w_cur_frame),
    .o_busy       (o_anim_busy),
    .o_done       (o_anim_done)
  );

  // One extra bit so a scan left of / above the box shows up as negative, not a wrapped hit.
  assign w_dx  = {1'b0, i_draw_x} - {1'b0, r_pos_x_sh};
  assign w_dy  = {1'b0, i_draw_y} - {1'b0, r_pos_y_sh};
  assign w_hit = i_blank & ~w_dx[POS_W] & ~w_dy[POS_W] &
                 (w_dx < (POS_W + 1)'(SPR_W)) & (w_dy < (POS_W + 1)'(SPR_H));

`ifdef SPRITE_FLIP_EN
  logic r_flip_sh;
  assign w_col = r_flip_sh ? ((POS_W + 1)'(SPR_W - 1) - w_dx) : w_dx;

  always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
    if (!i_reset_n)        r_flip_sh <= 1'b0;
    else if (i_frame_tick) r_flip_sh <= i_flip_h;
  end
`else
  logic w_unused_flip;
  assign w_unused_flip = i_flip_h;
  assign w_col         = w_dx;
`endif

  assign w_rom_addr = ADDR_W'(frame_base(32'(w_cur_frame), SPR_W, SPR_H) +
                              32'(w_dy) * SPR_W + 32'(w_col));

  always_ff @(posedge i_vga_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pos_x_sh   <= '0;
      r_pos_y_sh   <= '0;
      r_rom_addr   <= '0;
      r_hit_d      <= 1'b0;
      r_pix_idx    <= '0;
      r_pix_opaque <= 1'b0;
    end else begin
      if (i_frame_tick) begin
        r_pos_x_sh <= i_pos_x;
        r_pos_y_sh <= i_pos_y;
      end
      if (w_hit) r_rom_addr <= w_rom_addr;
      r_hit_d      <= w_hit;
      // i_rom_q was sampled by the ROM on the negedge using r_rom_addr.
      r_pix_idx    <= r_hit_d ? i_rom_q : '0;
      r_pix_opaque <= r_hit_d & (i_rom_q != IDX_W'(TRANSP_IDX));
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_pix_idx    = r_pix_idx;
  assign o_pix_opaque = r_pix_opaque;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer; ROM model returns (address LSBs + 1) so index 0
// (transparent) appears only at addresses ending in 7.
module tb_sprite_anim_renderer;

  localparam int unsigned FRM = 64 * 96;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y, pos_x, pos_y;
  logic        blank, frame_tick, flip_h, anim_start, anim_loop;
  logic [2:0]  anim_first, anim_last;
  logic [3:0]  anim_hold;
  logic [15:0] rom_addr;
  logic [2:0]  rom_q = 3'd0;
  logic [2:0]  pix_idx;
  logic        pix_opaque, anim_busy, anim_done;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_anim_renderer dut (
    .i_vga_clk    (clk),
    .i_reset_n    (reset_n),
    .i_draw_x     (draw_x),
    .i_draw_y     (draw_y),
    .i_blank      (blank),
    .i_frame_tick (frame_tick),
    .i_pos_x      (pos_x),
    .i_pos_y      (pos_y),
    .i_flip_h     (flip_h),
    .i_anim_start (anim_start),
    .i_anim_first (anim_first),
    .i_anim_last  (anim_last),
    .i_anim_hold  (anim_hold),
    .i_anim_loop  (anim_loop),
    .o_rom_addr   (rom_addr),
    .i_rom_q      (rom_q),
    .o_pix_idx    (pix_idx),
    .o_pix_opaque (pix_opaque),
    .o_anim_busy  (anim_busy),
    .o_anim_done  (anim_done)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) rom_q <= rom_addr[2:0] + 3'd1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic scan(input int x, input int y, input logic b);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = b;
    step();
  endtask

  int exp_seq[8] = '{2, 2, 3, 3, 4, 4, 2, 2};

  initial begin
    reset_n = 1'b0; draw_x = '0; draw_y = '0; blank = 1'b0; frame_tick = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; flip_h = 1'b0; anim_start = 1'b0;
    anim_first = '0; anim_last = '0; anim_hold = '0; anim_loop = 1'b1;
    repeat (2) step();
    check_eq("rst_addr", rom_addr, 0);
    check_eq("rst_idx", pix_idx, 0);
    check_eq("rst_opaque", pix_opaque, 0);
    check_eq("rst_busy", anim_busy, 0);
    check_eq("rst_done", anim_done, 0);
    reset_n = 1'b1;
    step();

    // start coinciding with a tick loads frame 0 and the sprite position at once
    anim_start = 1'b1; frame_tick = 1'b1; step(); anim_start = 1'b0; frame_tick = 1'b0;
    check_eq("busy_play", anim_busy, 1);

    scan(100, 50, 1'b1); check_eq("addr_origin", rom_addr, 0);
    scan(99, 50, 1'b1);
    check_eq("idx_origin", pix_idx, 1);
    check_eq("opq_origin", pix_opaque, 1);
    check_eq("addr_miss_hold", rom_addr, 0);
    scan(101, 51, 1'b1);
    check_eq("opq_left_miss", pix_opaque, 0);
    check_eq("idx_left_miss", pix_idx, 0);
    check_eq("addr_101_51", rom_addr, 65);
    scan(107, 50, 1'b1);
    check_eq("idx_65", pix_idx, 2);
    check_eq("opq_65", pix_opaque, 1);
    check_eq("addr_7", rom_addr, 7);
    scan(100, 50, 1'b0);
    check_eq("opq_transp", pix_opaque, 0);
    check_eq("idx_transp", pix_idx, 0);
    check_eq("addr_blank_hold", rom_addr, 7);
    scan(163, 145, 1'b1);
    check_eq("opq_blank", pix_opaque, 0);
    check_eq("addr_corner", rom_addr, FRM - 1);
    scan(164, 50, 1'b1); check_eq("addr_right_miss", rom_addr, FRM - 1);
    scan(100, 146, 1'b1); check_eq("addr_below_miss", rom_addr, FRM - 1);
    scan(0, 50, 1'b1); check_eq("addr_neg_miss", rom_addr, FRM - 1);

    flip_h = 1'b1; tick();
`ifdef SPRITE_FLIP_EN
    scan(100, 50, 1'b1); check_eq("flip_addr_a", rom_addr, 63);
    scan(163, 51, 1'b1); check_eq("flip_addr_b", rom_addr, 64);
`else
    scan(100, 50, 1'b1); check_eq("noflip_addr_a", rom_addr, 0);
    scan(163, 51, 1'b1); check_eq("noflip_addr_b", rom_addr, 127);
`endif
    flip_h = 1'b0; tick();

    pos_x = 10'd200;
    scan(110, 50, 1'b1); check_eq("pos_shadow_old", rom_addr, 10);
    tick();
    scan(210, 51, 1'b1); check_eq("pos_shadow_new", rom_addr, 74);
    scan(110, 50, 1'b1); check_eq("pos_old_miss", rom_addr, 74);
    pos_x = 10'd100; tick();

    anim_first = 3'd2; anim_last = 3'd4; anim_hold = 4'd1; anim_loop = 1'b1;
    anim_start = 1'b1; step(); anim_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("loop_done_%0d", i), anim_done, 0);
      scan(100, 50, 1'b1);
      check_eq($sformatf("loop_frame_%0d", i), rom_addr, exp_seq[i] * FRM);
    end

    anim_first = 3'd5; anim_last = 3'd5; anim_hold = 4'd0; anim_loop = 1'b0;
    anim_start = 1'b1; step(); anim_start = 1'b0;
    tick();
    check_eq("oneshot_done_early", anim_done, 0);
    check_eq("oneshot_busy", anim_busy, 1);
    scan(100, 50, 1'b1); check_eq("oneshot_addr", rom_addr, 5 * FRM);
    tick();
    check_eq("oneshot_done_pulse", anim_done, 1);
    check_eq("oneshot_busy_drop", anim_busy, 0);
    step();
    check_eq("oneshot_done_clear", anim_done, 0);
    tick();
    check_eq("oneshot_done_once", anim_done, 0);
    scan(100, 50, 1'b1); check_eq("oneshot_frozen", rom_addr, 5 * FRM);

    anim_first = 3'd6; anim_last = 3'd3; anim_loop = 1'b1;
    anim_start = 1'b1; frame_tick = 1'b1; step(); anim_start = 1'b0; frame_tick = 1'b0;
    scan(100, 50, 1'b1); check_eq("inverted_range", rom_addr, 3 * FRM);

    anim_first = 3'd1; anim_last = 3'd1;
    anim_start = 1'b1; frame_tick = 1'b1; step(); anim_start = 1'b0; frame_tick = 1'b0;
    scan(101, 50, 1'b1); check_eq("pre_rst_addr", rom_addr, FRM + 1);
    scan(101, 50, 1'b1);
    check_eq("pre_rst_opq", pix_opaque, 1);
    check_eq("pre_rst_idx", pix_idx, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_addr", rom_addr, 0);
    check_eq("async_rst_idx", pix_idx, 0);
    check_eq("async_rst_opq", pix_opaque, 0);
    check_eq("async_rst_busy", anim_busy, 0);
    #2 reset_n = 1'b1;
    step();
    check_eq("post_rst_busy", anim_busy, 0);
    tick();
    scan(101, 50, 1'b1); check_eq("post_rst_frame0", rom_addr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
